// File: rtl/timer_pkg.sv
// timer_pkg: state and mode encodings shared by the interval timer.
package timer_pkg;
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;
    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;
endpackage

// File: rtl/param_table.sv
// param_table: programmable interval table, one write port and one combinational read port.
module param_table #(
    parameter int WIDTH         = 8,
    parameter int NUM_PARAMS    = 4,
    parameter int SEL_W         = 2,
    parameter int DEFAULT_VALUE = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [SEL_W-1:0] waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [SEL_W-1:0] raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] r_mem [NUM_PARAMS];
    logic             w_waddr_ok;
    logic             w_raddr_ok;
    assign w_waddr_ok = 32'(waddr) < NUM_PARAMS;
    assign w_raddr_ok = 32'(raddr) < NUM_PARAMS;
    assign rdata      = w_raddr_ok ? r_mem[raddr] : '0;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_PARAMS; i++) r_mem[i] <= WIDTH'(DEFAULT_VALUE);
        end else if (we && w_waddr_ok) begin
            r_mem[waddr] <= wdata;
        end
    end
endmodule

// File: rtl/param_timer.sv
// param_timer: programmable down-counting interval timer with pause, abort and auto-reload.
module param_timer
    import timer_pkg::*;
#(
    parameter int WIDTH         = 8,
    parameter int NUM_PARAMS    = 4,
    parameter int SEL_W         = 2,
    parameter int DEFAULT_VALUE = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             start_timer,
    input  logic [SEL_W-1:0] parm_sel,
    input  logic             auto_reload,
    input  logic             pause,
    input  logic             abort,
    input  logic             prog_we,
    input  logic [SEL_W-1:0] prog_addr,
    input  logic [WIDTH-1:0] prog_data,
    output logic             expired,
    output logic             busy,
    output logic [WIDTH-1:0] remaining
);
    state_t           r_state, w_state_nx;
    logic [WIDTH-1:0] r_remaining, w_remaining_nx;
    logic [WIDTH-1:0] r_reload, w_reload_nx;
    logic             r_mode, w_mode_nx;
    logic             r_expired, w_expired_nx;
    logic [WIDTH-1:0] w_value;
    logic             w_start;
    logic             w_tick;

    param_table #(
        .WIDTH        (WIDTH),
        .NUM_PARAMS   (NUM_PARAMS),
        .SEL_W        (SEL_W),
        .DEFAULT_VALUE(DEFAULT_VALUE)
    ) u_table (
        .clk  (clk),
        .reset(reset),
        .we   (prog_we),
        .waddr(prog_addr),
        .wdata(prog_data),
        .raddr(parm_sel),
        .rdata(w_value)
    );

    assign w_start = start_timer && (32'(parm_sel) < NUM_PARAMS);
    assign w_tick  = (r_state == RUN) && enable && !pause;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_remaining <= '0;
            r_reload    <= '0;
            r_mode      <= MODE_ONESHOT;
            r_expired   <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_remaining <= w_remaining_nx;
            r_reload    <= w_reload_nx;
            r_mode      <= w_mode_nx;
            r_expired   <= w_expired_nx;
        end
    end

    // Priority abort > start > tick; a zero-valued start expires immediately from IDLE.
    always_comb begin
        w_state_nx     = r_state;
        w_remaining_nx = r_remaining;
        w_reload_nx    = r_reload;
        w_mode_nx      = r_mode;
        w_expired_nx   = 1'b0;
        if (abort) begin
            w_state_nx     = IDLE;
            w_remaining_nx = '0;
        end else if (w_start) begin
            w_reload_nx    = w_value;
            w_mode_nx      = auto_reload;
            w_state_nx     = (w_value != '0) ? RUN : IDLE;
            w_remaining_nx = w_value;
            w_expired_nx   = (w_value == '0);
        end else if (w_tick) begin
            if (r_remaining > WIDTH'(1)) begin
                w_remaining_nx = r_remaining - 1'b1;
            end else begin
                w_expired_nx   = 1'b1;
                w_state_nx     = (r_mode == MODE_PERIODIC) ? RUN : IDLE;
                w_remaining_nx = (r_mode == MODE_PERIODIC) ? r_reload : '0;
            end
        end
    end

    always_comb begin
        busy      = (r_state == RUN);
        expired   = r_expired;
        remaining = r_remaining;
    end
endmodule
